// File: rtl/pixel_sequencer.sv
// Replays a small instruction program once per pixel, walks x/y/frame coordinates and hands
// each finished pixel downstream with a valid/ready handshake.
module pixel_sequencer #(
  parameter int PROG_DEPTH = 64,
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        prog_we,
  input  logic [5:0]  prog_addr,
  input  logic [48:0] prog_data,
  input  logic [6:0]  prog_length,
  input  logic        run,
  output logic [48:0] instruction,
  output logic [31:0] x_coord,
  output logic [31:0] y_coord,
  output logic [31:0] f_number,
  output logic        pixel_valid,
  input  logic        pixel_ready,
  output logic        frame_done,
  output logic        busy
);

  localparam logic [48:0] NOP = 49'h1_E011_0000_0000;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXEC     = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

  state_t      state;
  logic [6:0]  len;
  logic [6:0]  pc;
  logic [6:0]  len_sat;
  logic [48:0] mem [PROG_DEPTH];

  assign len_sat = (prog_length > 7'(PROG_DEPTH)) ? 7'(PROG_DEPTH) : prog_length;
  assign busy    = (state != IDLE);

  // Program RAM: writable only while idle so a running program is never torn.
  always_ff @(posedge clk) begin
    if (prog_we && (state == IDLE)) begin
      mem[prog_addr] <= prog_data;
    end
  end

  // Handshake: a pixel transfers on any edge where pixel_valid && pixel_ready; pixel_valid
  // stays high and x/y/f stay frozen until then, and pixel_valid never drops without a transfer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      instruction <= NOP;
      x_coord     <= '0;
      y_coord     <= '0;
      f_number    <= '0;
      pc          <= '0;
      len         <= '0;
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (run && (prog_length != 7'd0)) begin
            state       <= EXEC;
            len         <= len_sat;
            pc          <= 7'd1;
            instruction <= mem[0];
          end
        end
        EXEC: begin
          if (pc < len) begin
            instruction <= mem[pc[5:0]];
            pc          <= pc + 7'd1;
          end else begin
            state       <= WAIT_ACK;
            instruction <= NOP;
            pixel_valid <= 1'b1;
          end
        end
        WAIT_ACK: begin
          if (pixel_ready) begin
            pixel_valid <= 1'b0;
            if (x_coord == 32'(WIDTH - 1)) begin
              x_coord <= '0;
              if (y_coord == 32'(HEIGHT - 1)) begin
                y_coord    <= '0;
                f_number   <= f_number + 32'd1;
                frame_done <= 1'b1;
              end else begin
                y_coord <= y_coord + 32'd1;
              end
            end else begin
              x_coord <= x_coord + 32'd1;
            end
            // Back-to-back pixels start the next program with no bubble cycle.
            if (run) begin
              state       <= EXEC;
              pc          <= 7'd1;
              instruction <= mem[0];
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state       <= IDLE;
          instruction <= NOP;
          pixel_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_sequencer.sv
// Self-checking bench for pixel_sequencer on a 4x2 frame: random programs, lengths and
// stalls checked slot by slot against a pixel-count reference model.
module tb_pixel_sequencer;

  localparam int W     = 4;
  localparam int H     = 2;
  localparam int DEPTH = 64;
  localparam logic [48:0] NOP = 49'h1_E011_0000_0000;

  logic        clk;
  logic        reset_n;
  logic        prog_we;
  logic [5:0]  prog_addr;
  logic [48:0] prog_data;
  logic [6:0]  prog_length;
  logic        run;
  logic [48:0] instruction;
  logic [31:0] x_coord;
  logic [31:0] y_coord;
  logic [31:0] f_number;
  logic        pixel_valid;
  logic        pixel_ready;
  logic        frame_done;
  logic        busy;

  pixel_sequencer #(.PROG_DEPTH(DEPTH), .WIDTH(W), .HEIGHT(H)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .prog_length (prog_length),
    .run         (run),
    .instruction (instruction),
    .x_coord     (x_coord),
    .y_coord     (y_coord),
    .f_number    (f_number),
    .pixel_valid (pixel_valid),
    .pixel_ready (pixel_ready),
    .frame_done  (frame_done),
    .busy        (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  // reference model: pixel index since reset, program image, latched length
  logic [48:0] m_prog [DEPTH];
  longint      m_pix;
  int          m_len;
  logic [48:0] exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic check_coords(input string tag);
    check({tag, ".x"}, 64'(x_coord), 64'(m_pix % W));
    check({tag, ".y"}, 64'(y_coord), 64'((m_pix / W) % H));
    check({tag, ".f"}, 64'(f_number), 64'(m_pix / (W * H)));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".instr"}, 64'(instruction), 64'(NOP));
    check({tag, ".valid"}, 64'(pixel_valid), 64'd0);
    check({tag, ".done"}, 64'(frame_done), 64'd0);
    check({tag, ".busy"}, 64'(busy), 64'd0);
    check({tag, ".x"}, 64'(x_coord), 64'd0);
    check({tag, ".y"}, 64'(y_coord), 64'd0);
    check({tag, ".f"}, 64'(f_number), 64'd0);
  endtask

  // driver tasks: all called and returning at a falling edge
  task automatic load(input int a, input logic [48:0] d);
    prog_addr = a[5:0];
    prog_data = d;
    prog_we   = 1'b1;
    @(negedge clk);
    prog_we   = 1'b0;
    m_prog[a] = d;
  endtask

  task automatic load_random(input int n);
    logic [63:0] r;
    for (int i = 0; i < n; i++) begin
      r = {$urandom, $urandom};
      load(i, r[48:0]);
    end
  endtask

  task automatic start(input int len_in);
    prog_length = 7'(len_in);
    run         = 1'b1;
    @(negedge clk);
    m_len = (len_in > DEPTH) ? DEPTH : len_in;
  endtask

  // One full pixel: program slots, stall cycles in the wait state, then the accept edge.
  task automatic pixel(input int stall, input int drop_slot);
    bit last;
    exp_q = {};
    for (int i = 0; i < m_len; i++) exp_q.push_back(m_prog[i]);
    for (int i = 0; i < m_len; i++) begin
      check("slot.instr", 64'(instruction), 64'(exp_q.pop_front()));
      check("slot.valid", 64'(pixel_valid), 64'd0);
      check("slot.busy", 64'(busy), 64'd1);
      check_coords("slot");
      if (i > 0) check("slot.done", 64'(frame_done), 64'd0);
      if (i == drop_slot) run = 1'b0;
      @(negedge clk);
    end
    for (int s = 0; s <= stall; s++) begin
      check("wait.instr", 64'(instruction), 64'(NOP));
      check("wait.valid", 64'(pixel_valid), 64'd1);
      check("wait.done", 64'(frame_done), 64'd0);
      check_coords("wait");
      pixel_ready = (s == stall);
      @(negedge clk);
    end
    pixel_ready = 1'b0;
    last  = ((m_pix + 1) % (W * H)) == 0;
    m_pix = m_pix + 1;
    check("accept.valid", 64'(pixel_valid), 64'd0);
    check("accept.done", 64'(frame_done), 64'(last));
    check_coords("accept");
    if (run) begin
      check("accept.next_instr", 64'(instruction), 64'(m_prog[0]));
      check("accept.busy", 64'(busy), 64'd1);
    end else begin
      check("accept.idle_instr", 64'(instruction), 64'(NOP));
      check("accept.busy", 64'(busy), 64'd0);
    end
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    run     = 1'b0;
    @(negedge clk);
    check_reset_values("reset");
    reset_n = 1'b1;
    m_pix   = 0;
  endtask

  initial begin
    int len;
    int npix;
    logic [48:0] saved;
    reset_n     = 1'b0;
    prog_we     = 1'b0;
    prog_addr   = '0;
    prog_data   = '0;
    prog_length = '0;
    run         = 1'b0;
    pixel_ready = 1'b0;
    m_pix       = 0;
    m_len       = 0;
    repeat (2) @(negedge clk);
    apply_reset();

    // three-instruction program, ready held high, then stop
    load_random(3);
    start(3);
    pixel(0, -1);
    pixel(0, 0);

    // stalled handshake
    start(3);
    pixel(5, -1);
    pixel(2, 1);

    // run dropped during slot 1 of a four-instruction pixel
    load_random(4);
    start(4);
    pixel(0, 1);

    // zero length never leaves idle
    prog_length = 7'd0;
    run         = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("zero_len.busy", 64'(busy), 64'd0);
      check("zero_len.instr", 64'(instruction), 64'(NOP));
    end
    run = 1'b0;
    @(negedge clk);

    // writes while busy are ignored
    start(2);
    saved     = m_prog[0];
    prog_addr = 6'd0;
    prog_data = ~saved;
    prog_we   = 1'b1;
    pixel(0, 0);
    prog_we   = 1'b0;
    start(2);
    pixel(0, 0);

    // length above the RAM depth saturates
    load_random(DEPTH);
    start(100);
    pixel(1, 0);

    // random programs, lengths, stalls and stop points; prog_length noise mid-run
    for (int it = 0; it < 20; it++) begin
      load_random(8);
      len = $urandom_range(1, 6);
      start(len);
      prog_length = 7'($urandom_range(0, 127));
      npix = $urandom_range(1, 4);
      for (int k = 0; k < npix; k++)
        pixel($urandom_range(0, 3), (k == npix - 1) ? $urandom_range(0, len - 1) : -1);
    end

    // asynchronous reset in the middle of execution
    load_random(4);
    start(4);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check_reset_values("async_reset");
    run = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    m_pix   = 0;
    @(negedge clk);
    check_reset_values("post_reset");

    // one full frame of single-instruction pixels
    start(1);
    for (int k = 0; k < W * H; k++) pixel(0, (k == W * H - 1) ? 0 : -1);
    check("frame.x", 64'(x_coord), 64'd0);
    check("frame.y", 64'(y_coord), 64'd0);
    check("frame.f", 64'(f_number), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
